mem_stage_ctrl: RTL and testbench

//  Memory stage of the 5-stage pipeline, directly downstream of the EX/M latch.

---
 rtl/mem_stage_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory stage control: data-cache request/stall FSM, M/WB latch and optional LL/SC link register.
// Optional feature macro: MEM_LLSC_EN (builds the link register and conditional SC).
module mem_stage_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              datomic_in,
  input  logic [ADDR_W-1:0] portO,
  input  logic [ADDR_W-1:0] dmemStore,
  input  logic              MemtoReg,
  input  logic              wdatasrc,
  input  logic [ADDR_W-1:0] pcp4,
  input  logic [4:0]        WSel,
  input  logic              WEN,
  input  logic              HALT,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_WEN,
  output logic [4:0]        wb_WSel,
  output logic [ADDR_W-1:0] wb_wdat,
  output logic              wb_HALT,
  output logic              state_dbg
);

  // Handshake: a request (dmemREN/dmemWEN) is held high until the cycle dhit is seen;
  // dhit completes it in that same cycle, and EX/M inputs stay stable while mem_stall=1.
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] hold_data, load_data, wdat_next;
  logic              sc_op, sc_ok, mem_op, complete, capture, advance;

  assign sc_op = dWEN_in & datomic_in;

`ifdef MEM_LLSC_EN
  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;

  assign sc_ok = ~sc_op | (link_valid & (link_addr == portO));

  // Clears come first so a same-cycle LL set overrides a snoop clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (snoop_inv && (snoop_addr == link_addr))
        link_valid <= 1'b0;
      if (complete && dWEN_in && (portO == link_addr))
        link_valid <= 1'b0;
      if (complete && dREN_in && datomic_in) begin
        link_valid <= 1'b1;
        link_addr  <= portO;
      end
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_inv, snoop_addr};
  assign sc_ok        = 1'b1;
`endif

  assign mem_op    = (dREN_in | (dWEN_in & sc_ok)) & nRST;
  assign complete  = (state == IDLE) & mem_op & dhit;
  assign capture   = complete & ~en;
  assign dmemaddr  = portO;
  assign dmemstore = dmemStore;
  assign state_dbg = (state == DONE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        dmemREN   = dREN_in & nRST;
        dmemWEN   = dWEN_in & sc_ok & nRST;
        mem_stall = mem_op & ~dhit;
        if (capture) state_next = DONE;
      end
      DONE: begin
        // Access already finished; wait for the pipeline to unfreeze.
        if (en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        hold_data <= '0;
    else if (capture) hold_data <= dmemload;
  end

  assign load_data = (state == DONE) ? hold_data : dmemload;
  assign advance   = en & ~mem_stall;

  // SC writes back its success flag instead of any datapath value.
  always_comb begin
    wdat_next = portO;
    if (sc_op)         wdat_next = {{(ADDR_W-1){1'b0}}, sc_ok};
    else if (MemtoReg) wdat_next = load_data;
    else if (wdatasrc) wdat_next = pcp4;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_WEN  <= 1'b0;
      wb_WSel <= '0;
      wb_wdat <= '0;
      wb_HALT <= 1'b0;
    end else if (advance) begin
      wb_WEN  <= WEN & ~flush;
      wb_WSel <= WSel;
      wb_wdat <= wdat_next;
      wb_HALT <= (HALT_STICKY & wb_HALT) | (HALT & ~flush);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: scoreboard of expected M/WB words plus scenario tasks.
// Expectations for LL/SC follow MEM_LLSC_EN when it is defined for the build.
module tb_mem_stage_ctrl;

`ifdef MEM_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic        CLK, nRST, en, flush, dREN_in, dWEN_in, datomic_in;
  logic [31:0] portO, dmemStore, pcp4, dmemload, snoop_addr;
  logic        MemtoReg, wdatasrc, WEN, HALT, dhit, snoop_inv;
  logic [4:0]  WSel;
  logic        dmemREN, dmemWEN, mem_stall, wb_WEN, wb_HALT, state_dbg;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_WSel;

  logic [37:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .dREN_in(dREN_in),
    .dWEN_in(dWEN_in), .datomic_in(datomic_in), .portO(portO), .dmemStore(dmemStore),
    .MemtoReg(MemtoReg), .wdatasrc(wdatasrc), .pcp4(pcp4), .WSel(WSel), .WEN(WEN),
    .HALT(HALT), .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv),
    .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_WEN(wb_WEN), .wb_WSel(wb_WSel),
    .wb_wdat(wb_wdat), .wb_HALT(wb_HALT), .state_dbg(state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    dREN_in = 0; dWEN_in = 0; datomic_in = 0; MemtoReg = 0; wdatasrc = 0;
    WEN = 0; dhit = 0; WSel = 0;
  endtask

  task automatic check_wb();
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (wb_WEN !== e[37]) begin errors++; $display("FAIL wb_WEN got %0b want %0b", wb_WEN, e[37]); end
    checks++;
    if (wb_WSel !== e[36:32]) begin errors++; $display("FAIL wb_WSel got %0d want %0d", wb_WSel, e[36:32]); end
    checks++;
    if (wb_wdat !== e[31:0]) begin errors++; $display("FAIL wb_wdat got %08h want %08h", wb_wdat, e[31:0]); end
  endtask

  // Issues one EX/M instruction at posedge+1 with en=1; the cache answers lat cycles later.
  task automatic do_op(input logic ren, input logic wreq, input logic atomic,
                       input logic [31:0] addr, input logic m2r, input logic wsrc,
                       input logic wen, input logic [4:0] wsel, input int lat,
                       input logic exp_dwen);
    logic [31:0] data, exp_wdat;
    logic        req, stalled;
    int          c;
    data = $urandom;
    pcp4 = $urandom;
    req  = ren | exp_dwen;
    exp_wdat = m2r ? data : (wsrc ? pcp4 : addr);
    if (wreq & atomic) exp_wdat = exp_dwen ? 32'd1 : 32'd0;
    exp_q.push_back({wen & ~flush, wsel, exp_wdat});
    en = 1; dREN_in = ren; dWEN_in = wreq; datomic_in = atomic; portO = addr;
    dmemStore = $urandom; MemtoReg = m2r; wdatasrc = wsrc; WEN = wen; WSel = wsel;
    c = 0;
    dhit = req && (lat == 0);
    dmemload = dhit ? data : $urandom;
    stalled = 1'b1;
    while (stalled && c <= lat + 5) begin
      @(negedge CLK);
      if (c == 0) begin
        checks++;
        if (dmemWEN !== exp_dwen) begin errors++; $display("FAIL dmemWEN got %0b want %0b", dmemWEN, exp_dwen); end
        checks++;
        if (dmemaddr !== addr) begin errors++; $display("FAIL dmemaddr got %08h want %08h", dmemaddr, addr); end
      end
      if (mem_stall) begin
        checks++;
        if (dmemREN !== ren) begin errors++; $display("FAIL dmemREN_held got %0b want %0b", dmemREN, ren); end
      end
      stalled = mem_stall;
      @(posedge CLK); #1;
      if (stalled) begin
        c++;
        dhit = req && (c == lat);
        dmemload = dhit ? data : $urandom;
      end
    end
    checks++;
    if (stalled) begin
      errors++; $display("FAIL stall_timeout got %0d cycles want %0d", c, lat);
    end else if (c != (req ? lat : 0)) begin
      errors++; $display("FAIL stall_cycles got %0d want %0d", c, req ? lat : 0);
    end
    check_wb();
    clear_inputs();
  endtask

  task automatic idle_cycle(input logic inv, input logic [31:0] a);
    snoop_inv = inv; snoop_addr = a;
    @(posedge CLK); #1;
    snoop_inv = 0;
  endtask

  task automatic test_reset();
    nRST = 0; en = 1; flush = 0; HALT = 0; snoop_inv = 0; snoop_addr = 0;
    portO = 0; dmemStore = 0; pcp4 = 0; dmemload = 0;
    clear_inputs();
    dREN_in = 1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, state_dbg} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %04b want 0000", {dmemREN, dmemWEN, mem_stall, state_dbg});
    end
    checks++;
    if ({wb_WEN, wb_WSel, wb_wdat, wb_HALT} !== 39'd0) begin
      errors++; $display("FAIL reset_wb got %0h want 0", {wb_WEN, wb_WSel, wb_wdat, wb_HALT});
    end
    dREN_in = 0;
    nRST = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_zero_wait();
    do_op(1, 0, 0, 32'h100, 1, 0, 1, 5'd1, 0, 0);
    do_op(0, 1, 0, 32'h104, 0, 0, 0, 5'd0, 0, 1);
  endtask

  task automatic test_latency();
    do_op(1, 0, 0, 32'h108, 1, 0, 1, 5'd2, 3, 0);
    do_op(0, 1, 0, 32'h10c, 0, 0, 0, 5'd0, 2, 1);
  endtask

  task automatic test_alu_jal();
    do_op(0, 0, 0, 32'hdead_beef, 0, 0, 1, 5'd9, 0, 0);
    do_op(0, 0, 0, 32'h0000_0044, 0, 1, 1, 5'd31, 0, 0);
  endtask

  task automatic test_frozen();
    logic [31:0] d;
    d = $urandom;
    exp_q.push_back({1'b1, 5'd7, d});
    en = 0; dREN_in = 1; portO = 32'h180; MemtoReg = 1; WEN = 1; WSel = 5'd7;
    dhit = 1; dmemload = d;
    @(negedge CLK);
    checks++;
    if (mem_stall !== 1'b0 || dmemREN !== 1'b1) begin
      errors++; $display("FAIL frozen_hit got stall=%0b ren=%0b want stall=0 ren=1", mem_stall, dmemREN);
    end
    @(posedge CLK); #1;
    dhit = 0; dmemload = $urandom;
    checks++;
    if (state_dbg !== 1'b1) begin errors++; $display("FAIL frozen_state got %0b want 1", state_dbg); end
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL frozen_done got ren=%0b stall=%0b want 0 0", dmemREN, mem_stall);
    end
    @(posedge CLK); #1;
    dmemload = $urandom;
    en = 1;
    @(posedge CLK); #1;
    check_wb();
    checks++;
    if (state_dbg !== 1'b0) begin errors++; $display("FAIL frozen_exit got %0b want 0", state_dbg); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_op(1, 0, 0, $urandom, 1, 0, 1, 5'($urandom_range(1, 31)), $urandom_range(0, 3), 0);
        1: do_op(0, 1, 0, $urandom, 0, 0, 0, 5'd0, $urandom_range(0, 3), 1);
        2: do_op(0, 0, 0, $urandom, 0, 0, 1, 5'($urandom_range(1, 31)), 0, 0);
        default: do_op(0, 0, 0, $urandom, 0, 1, 1, 5'd31, 0, 0);
      endcase
    end
  endtask

  task automatic test_flush();
    flush = 1;
    do_op(1, 0, 0, 32'h1c0, 1, 0, 1, 5'd12, 2, 0);
    flush = 0;
  endtask

  task automatic test_llsc();
    do_op(1, 0, 1, 32'h200, 1, 0, 1, 5'd3, 1, 0);
    do_op(0, 1, 1, 32'h200, 0, 0, 1, 5'd4, 2, 1);
    do_op(0, 1, 1, 32'h200, 0, 0, 1, 5'd4, LLSC ? 0 : 1, !LLSC);
    do_op(1, 0, 1, 32'h200, 1, 0, 1, 5'd3, 0, 0);
    idle_cycle(1, 32'h200);
    do_op(0, 1, 1, 32'h200, 0, 0, 1, 5'd5, 0, !LLSC);
    do_op(1, 0, 1, 32'h300, 1, 0, 1, 5'd3, 0, 0);
    idle_cycle(1, 32'h304);
    do_op(0, 1, 1, 32'h300, 0, 0, 1, 5'd6, 1, 1);
    do_op(1, 0, 1, 32'h400, 1, 0, 1, 5'd3, 0, 0);
    do_op(0, 1, 0, 32'h400, 0, 0, 0, 5'd0, 1, 1);
    do_op(0, 1, 1, 32'h400, 0, 0, 1, 5'd7, 0, !LLSC);
  endtask

  task automatic test_halt();
    HALT = 1;
    do_op(0, 0, 0, 32'h0, 0, 0, 0, 5'd0, 0, 0);
    HALT = 0;
    checks++;
    if (wb_HALT !== 1'b1) begin errors++; $display("FAIL halt_set got %0b want 1", wb_HALT); end
    flush = 1;
    do_op(0, 0, 0, 32'h11, 0, 0, 1, 5'd8, 0, 0);
    flush = 0;
    checks++;
    if (wb_HALT !== 1'b1) begin errors++; $display("FAIL halt_flush got %0b want 1", wb_HALT); end
    do_op(1, 0, 0, 32'h120, 1, 0, 1, 5'd9, 1, 0);
    checks++;
    if (wb_HALT !== 1'b1) begin errors++; $display("FAIL halt_sticky got %0b want 1", wb_HALT); end
    dREN_in = 1; portO = 32'h140; dhit = 0;
    @(negedge CLK);
    checks++;
    if (mem_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %0b want 1", mem_stall); end
    #2 nRST = 0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, state_dbg} !== 4'b0) begin
      errors++; $display("FAIL midreset_ctrl got %04b want 0000", {dmemREN, dmemWEN, mem_stall, state_dbg});
    end
    checks++;
    if ({wb_WEN, wb_WSel, wb_wdat, wb_HALT} !== 39'd0) begin
      errors++; $display("FAIL midreset_wb got %0h want 0", {wb_WEN, wb_WSel, wb_wdat, wb_HALT});
    end
    @(posedge CLK); #1;
    clear_inputs();
    nRST = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_alu_jal();
    test_frozen();
    test_back_to_back();
    test_flush();
    test_llsc();
    test_halt();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
